// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file and its clear sequencer.
package regfile_pkg;

  localparam int RF_WIDTH    = 16;
  localparam int RF_DEPTH    = 8;
  localparam int RF_NREAD    = 2;
  localparam int RF_ZERO_REG = 1;
  localparam int RF_BYPASS   = 1;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

  function automatic int rf_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks idx 0..DEPTH-1 zeroing one entry per cycle and
// tells the array when ordinary writes may commit.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = rf_aw(DEPTH)
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Clear,
  output logic          Busy,
  output logic          ClrEn,
  output logic          WrOk,
  output logic [AW-1:0] ClrIdx
);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= RF_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    Busy      = 1'b0;
    ClrEn     = 1'b0;
    WrOk      = 1'b0;
    case (state)
      RF_IDLE: begin
        // the cycle that accepts Clear drops its writes
        WrOk = !Clear;
        if (Clear) begin
          state_nxt = RF_CLEAR;
          idx_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        Busy  = 1'b1;
        ClrEn = 1'b1;
        if (idx == AW'(DEPTH - 1)) begin
          state_nxt = RF_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  assign ClrIdx = idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised write
// ports, optional write bypass and zero register, sequenced clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = RF_NREAD,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int BYPASS   = RF_BYPASS,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic [NREAD*AW-1:0]    RdAddr,
  output logic [NREAD*WIDTH-1:0] RdData,
  input  logic                   WrEnA,
  input  logic [AW-1:0]          WrAddrA,
  input  logic [WIDTH-1:0]       WrDataA,
  input  logic                   WrEnB,
  input  logic [AW-1:0]          WrAddrB,
  input  logic [WIDTH-1:0]       WrDataB,
  input  logic                   Clear,
  output logic                   Busy
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        clr_en, wr_ok;
  logic [AW-1:0]               clr_idx;
  logic                        we_a, we_b;

  regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Clear  (Clear),
    .Busy   (Busy),
    .ClrEn  (clr_en),
    .WrOk   (wr_ok),
    .ClrIdx (clr_idx)
  );

  // effective enables: only in IDLE, never to a hard-wired r0, B loses a tie
  assign we_a = wr_ok && WrEnA && !(ZERO_REG != 0 && WrAddrA == '0);
  assign we_b = wr_ok && WrEnB && !(ZERO_REG != 0 && WrAddrB == '0)
                && !(WrEnA && WrAddrA == WrAddrB);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_en && clr_idx == AW'(i))
          regs[i] <= '0;
        else if (we_a && WrAddrA == AW'(i))
          regs[i] <= WrDataA;
        else if (we_b && WrAddrB == AW'(i))
          regs[i] <= WrDataB;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = RdAddr[k*AW +: AW];

    always_comb begin
      data = regs[addr];
      if (BYPASS != 0) begin
        if (we_a && WrAddrA == addr)
          data = WrDataA;
        else if (we_b && WrAddrB == addr)
          data = WrDataB;
      end
      if (ZERO_REG != 0 && addr == '0)
        data = '0;
    end

    assign RdData[k*WIDTH +: WIDTH] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default file, a no-bypass twin on the same inputs, and a
// wide 32x32 three-read-port instance.
module tb_regfile_mp;

  logic        Clock, ResetN;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data, nb_rd_data;
  logic        busy, nb_busy;
  logic        wea, web, clear;
  logic [2:0]  waa, wab;
  logic [15:0] wda, wdb;

  logic [14:0] w_rd_addr;
  logic [95:0] w_rd_data;
  logic        w_busy, w_wea, w_web, w_clear;
  logic [4:0]  w_waa, w_wab;
  logic [31:0] w_wda, w_wdb;

  int n_chk, n_fail;
  int busy_cyc, cnt;

  regfile_mp u_dut (
    .Clock(Clock), .ResetN(ResetN), .RdAddr(rd_addr), .RdData(rd_data),
    .WrEnA(wea), .WrAddrA(waa), .WrDataA(wda),
    .WrEnB(web), .WrAddrB(wab), .WrDataB(wdb),
    .Clear(clear), .Busy(busy)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .Clock(Clock), .ResetN(ResetN), .RdAddr(rd_addr), .RdData(nb_rd_data),
    .WrEnA(wea), .WrAddrA(waa), .WrDataA(wda),
    .WrEnB(web), .WrAddrB(wab), .WrDataB(wdb),
    .Clear(clear), .Busy(nb_busy)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(3), .ZERO_REG(0), .BYPASS(1)) u_wide (
    .Clock(Clock), .ResetN(ResetN), .RdAddr(w_rd_addr), .RdData(w_rd_data),
    .WrEnA(w_wea), .WrAddrA(w_waa), .WrDataA(w_wda),
    .WrEnB(w_web), .WrAddrB(w_wab), .WrDataB(w_wdb),
    .Clear(w_clear), .Busy(w_busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input logic [2:0] p0, input logic [2:0] p1);
    rd_addr = {p1, p0};
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ResetN = 1'b0;
    rd_addr = '0; wea = 0; web = 0; waa = '0; wab = '0; wda = '0; wdb = '0; clear = 0;
    w_rd_addr = '0; w_wea = 0; w_web = 0; w_waa = '0; w_wab = '0; w_wda = '0; w_wdb = '0; w_clear = 0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rd", rd_data, 32'd0);
    chk("reset_wide_rd", w_rd_data[31:0], 32'd0);
    #10 ResetN = 1'b1;

    // first write right after reset release, with same-cycle bypass
    rd(3'd3, 3'd3); wea = 1; waa = 3'd3; wda = 16'hBEEF;
    #1;
    chk("byp_p0", {16'd0, rd_data[15:0]}, 32'h0000BEEF);
    chk("byp_p1", {16'd0, rd_data[31:16]}, 32'h0000BEEF);
    chk("nobyp_old", {16'd0, nb_rd_data[31:16]}, 32'h0);
    tick; wea = 0;
    chk("r3_p0", {16'd0, rd_data[15:0]}, 32'h0000BEEF);
    chk("r3_p1", {16'd0, rd_data[31:16]}, 32'h0000BEEF);
    chk("nb_r3", {16'd0, nb_rd_data[15:0]}, 32'h0000BEEF);

    // zero register
    wea = 1; waa = 3'd0; wda = 16'h1234; rd(3'd0, 3'd3);
    #1 chk("r0_byp_zero", {16'd0, rd_data[15:0]}, 32'h0);
    tick; wea = 0;
    chk("r0_zero", {16'd0, rd_data[15:0]}, 32'h0);
    chk("nb_r0_zero", {16'd0, nb_rd_data[15:0]}, 32'h0);

    // collision: A wins
    wea = 1; waa = 3'd5; wda = 16'h00AA; web = 1; wab = 3'd5; wdb = 16'h0055; rd(3'd5, 3'd5);
    #1 chk("coll_byp", {16'd0, rd_data[15:0]}, 32'h000000AA);
    tick; wea = 0; wab = 3'd6; wdb = 16'h0077; rd(3'd5, 3'd6);
    #1;
    chk("coll_r5", {16'd0, rd_data[15:0]}, 32'h000000AA);
    chk("byp_b_r6", {16'd0, rd_data[31:16]}, 32'h00000077);
    chk("nb_r6_old", {16'd0, nb_rd_data[31:16]}, 32'h0);
    tick; web = 0;
    chk("nb_r6", {16'd0, nb_rd_data[31:16]}, 32'h00000077);
    chk("nb_r5", {16'd0, nb_rd_data[15:0]}, 32'h000000AA);

    // both ports hit the read address: A data returned
    wea = 1; waa = 3'd2; wda = 16'hCAFE; web = 1; wab = 3'd2; wdb = 16'h1111; rd(3'd0, 3'd2);
    #1;
    chk("byp_ab_r2", {16'd0, rd_data[31:16]}, 32'h0000CAFE);
    chk("nb_r2_old", {16'd0, nb_rd_data[31:16]}, 32'h0);
    tick; wea = 0; web = 0;
    chk("nb_r2", {16'd0, nb_rd_data[31:16]}, 32'h0000CAFE);

    // fill and sequenced clear
    for (int i = 0; i < 8; i++) begin
      wea = 1; waa = 3'(i); wda = 16'h1000 + 16'(i);
      tick;
    end
    wea = 0; rd(3'd4, 3'd7);
    clear = 1;
    #1 chk("busy_pre_clear", {31'd0, busy}, 32'd0);
    tick; clear = 0;
    chk("busy_after_e0", {31'd0, busy}, 32'd1);
    tick;
    busy_cyc = 1;
    for (int e = 1; e <= 8; e++) begin
      if (busy) busy_cyc++;
      if (e == 1) chk("r7_mid_clear", {16'd0, rd_data[31:16]}, 32'h00001007);
      if (e == 4) chk("r4_before_e5", {16'd0, rd_data[15:0]}, 32'h00001004);
      if (e == 5) begin
        wea = 1; waa = 3'd3; wda = 16'h5555; rd(3'd4, 3'd3);
        #1;
        chk("r4_after_e5", {16'd0, rd_data[15:0]}, 32'h0);
        chk("no_byp_busy", {16'd0, rd_data[31:16]}, 32'h0);
      end
      if (e == 6) wea = 0;
      if (e < 8) tick;
    end
    chk("busy_fell", {31'd0, busy}, 32'd0);
    chk("busy_cycles", 32'(busy_cyc), 32'd8);

    // write presented as Busy falls is accepted
    wea = 1; waa = 3'd4; wda = 16'h4444;
    tick; wea = 0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 3'(a));
      #1 chk("post_clear", {16'd0, rd_data[15:0]}, (a == 4) ? 32'h00004444 : 32'h0);
    end

    // reset in the third Busy cycle
    rd(3'd4, 3'd4); clear = 1;
    tick; clear = 0;
    tick; tick;
    chk("busy_3rd", {31'd0, busy}, 32'd1);
    chk("r4_before_rst", {16'd0, rd_data[15:0]}, 32'h00004444);
    #1 ResetN = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_nb_rd", nb_rd_data, 32'd0);
    #1 ResetN = 1'b1;
    wea = 1; waa = 3'd1; wda = 16'h0101; rd(3'd1, 3'd1);
    tick; wea = 0;
    chk("r1_after_rst", {16'd0, nb_rd_data[15:0]}, 32'h00000101);
    chk("busy_after_rst", {31'd0, busy}, 32'd0);

    // wide instance
    w_wea = 1; w_waa = 5'd0; w_wda = 32'hDEADBEEF;
    w_web = 1; w_wab = 5'd31; w_wdb = 32'h12345678;
    tick; w_wea = 0; w_web = 0;
    w_rd_addr = {5'd0, 5'd31, 5'd0};
    #1;
    chk("w_p0_r0", w_rd_data[31:0], 32'hDEADBEEF);
    chk("w_p1_r31", w_rd_data[63:32], 32'h12345678);
    chk("w_p2_r0", w_rd_data[95:64], 32'hDEADBEEF);
    w_clear = 1;
    tick; w_clear = 0;
    cnt = 0;
    for (int c = 0; c < 40 && w_busy; c++) begin
      cnt++;
      tick;
    end
    chk("w_busy_cycles", 32'(cnt), 32'd32);
    chk("w_r0_cleared", w_rd_data[31:0], 32'h0);
    chk("w_r31_cleared", w_rd_data[63:32], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
